softmax_frame_buffer: RTL
=========================

# softmax_frame_buffer

Parametrised frame buffer and running-max tracker for the softmax datapath: captures a frame of NUM_DATA floating-point logits, finds the frame maximum on the fly, then replays the frame in order with a valid/ready handshake so the downscale/exp stage can compute x − max. It sits between the input stream and the downscale→exp→adder chain. It generalises the fixed 10-word, no-backpressure input path to any width and depth, with output flow control.

## Interface
- DATA_WIDTH, 32, word width; MSB is sign, remaining bits are biased-exponent‖mantissa (IEEE-754 layout, any format)
- NUM_DATA, 10, words per frame (≥2)
- ADDR_WIDTH (localparam), $clog2(NUM_DATA), index width

- clock_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  frame start pulse, honoured only in IDLE
- data_valid_i  in  1  qualifies data_i
- data_i  in  DATA_WIDTH  input logit
- busy_o  out  1  high in LOAD and REPLAY
- max_valid_o  out  1  one-cycle pulse when max_o is final
- max_o  out  DATA_WIDTH  frame maximum, held until next start
- data_valid_o  out  1  replay word valid
- data_ready_i  in  1  downstream accepts replay word
- data_o  out  DATA_WIDTH  replay word
- index_o  out  ADDR_WIDTH  index of data_o within frame
- last_o  out  1  data_o is element NUM_DATA−1

## Operation
- States: IDLE, LOAD, REPLAY. Storage: NUM_DATA×DATA_WIDTH flop array; wr_cnt, rd_ptr counters.
- IDLE: start_i → LOAD, wr_cnt←0. If data_valid_i is high in the same cycle as start_i, that word is element 0 (wr_cnt←1, max←data_i).
- LOAD: each data_valid_i cycle writes mem[wr_cnt], wr_cnt++. Gaps (data_valid_i low) allowed, no effect. Write of element NUM_DATA−1 → REPLAY, rd_ptr←0.
- Max tracking: element 0 loads max unconditionally; later elements replace max only if strictly greater. Compare: signs differ → non-negative wins, except ±0 compare equal; both positive → larger magnitude wins; both negative → smaller magnitude wins. Ties keep the earliest element. NaN/Inf not handled (treated as ordinary magnitudes).
- REPLAY: data_valid_o=1, data_o=mem[rd_ptr], index_o=rd_ptr, last_o=(rd_ptr==NUM_DATA−1). Transfer on data_valid_o&&data_ready_i → rd_ptr++; outputs hold while ready is low. Transfer with last_o → IDLE.
- start_i outside IDLE and data_valid_i outside LOAD/IDLE-start are ignored.
- Reset (any state, including mid-LOAD/REPLAY): state IDLE, counters 0, all outputs 0, max register 0; the partial frame is discarded. Memory contents need not reset.

## Timing
- Reset values: busy_o, max_valid_o, max_o, data_valid_o, data_o, index_o, last_o all 0.
- Last input word accepted in cycle T → REPLAY, busy_o, data_valid_o and max_valid_o (single pulse) all high in T+1; data_o=element 0 in T+1.
- With data_ready_i held high: one word per cycle, elements at T+1…T+NUM_DATA, IDLE at T+NUM_DATA+1; a new start_i is accepted in T+NUM_DATA+1.
- max_o valid from T+1 and held through REPLAY and IDLE until the next frame's element 0 is captured.
- data_o/index_o/last_o change only on transfer or state change.

## Configuration
- SOFTMAX_BUF_MAX_EN defined: comparator and max register built as above.
- Undefined: no comparator synthesised; max_o constant 0; max_valid_o still pulses at T+1 (downstream subtracts 0, i.e. raw pass-through).

## Test plan
- Ten-word frame C05060D2, 40A5D0A4, BF3A1674, 401D24F6, BE3BD70A, 3F461F7D, C0350DF4, 40BEEE67, C0A6D2C4, 3F9DF3B6 applied with start_i, ready=1 → max_valid_o pulse one cycle after last word, max_o=40BEEE67, words replayed in order on 10 consecutive cycles, last_o only with 3F9DF3B6.
- NUM_DATA=3, all-negative C05060D2, BF3A1674, C0A6D2C4 → max_o=BF3A1674.
- Zero tie: 80000000 then 00000000 (NUM_DATA=2) → max_o=80000000 (first kept); 3F800000 vs 3F800000 → first kept.
- Backpressure: data_ready_i toggling 1,0,0,1… → data_o/index_o hold while low, no word skipped or duplicated, exactly NUM_DATA transfers.
- Gapped input (valid 1,0,1,0…) plus start_i pulsed during REPLAY → frame captured correctly, stray start ignored.
- reset_i asserted mid-REPLAY → all outputs 0 immediately, IDLE; following frame processed correctly; repeat with macro undefined → max_o stays 0.

Source files
------------

// File: rtl/softmax_frame_buffer.sv
// Frame buffer for the softmax datapath: captures NUM_DATA logits, tracks their maximum, then replays them with valid/ready.
// Optional macro SOFTMAX_BUF_MAX_EN builds the max comparator; when it is undefined, max_o is tied to 0.
//
// state  | meaning
// IDLE   | waiting for start_i; max_o holds the previous frame's maximum
// LOAD   | writing incoming words into mem, tracking the running maximum
// REPLAY | presenting mem[rd_ptr] downstream, advancing on each transfer
module softmax_frame_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_DATA   = 10,
   localparam int ADDR_WIDTH = $clog2(NUM_DATA)
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic                  data_valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  busy_o,
   output logic                  max_valid_o,
   output logic [DATA_WIDTH-1:0] max_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [ADDR_WIDTH-1:0] index_o,
   output logic                  last_o
);

   typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_DATA - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_cnt_q, rd_ptr_q, wr_idx;
   logic                  wr_en, xfer, max_valid_q;
   logic [DATA_WIDTH-1:0] mem [0:NUM_DATA-1];

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      wr_idx  = wr_cnt_q;
      xfer    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD;
               wr_idx  = '0;
               wr_en   = data_valid_i;
            end
         end
         LOAD: begin
            wr_en = data_valid_i;
            if (data_valid_i && (wr_cnt_q == LAST_IDX)) state_d = REPLAY;
         end
         REPLAY: begin
            xfer = data_ready_i;
            if (data_ready_i && (rd_ptr_q == LAST_IDX)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         wr_cnt_q    <= '0;
         rd_ptr_q    <= '0;
         max_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         max_valid_q <= (state_q == LOAD) && (state_d == REPLAY);
         if ((state_q == IDLE) && start_i)
            wr_cnt_q <= data_valid_i ? ONE_IDX : '0;
         else if ((state_q == LOAD) && data_valid_i)
            wr_cnt_q <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + ONE_IDX;
         if (xfer)
            rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + ONE_IDX;
      end
   end

   // Storage is never reset; a discarded partial frame is simply overwritten.
   always_ff @(posedge clock_i) begin
      if (wr_en) mem[wr_idx] <= data_i;
   end

`ifdef SOFTMAX_BUF_MAX_EN
   logic [DATA_WIDTH-1:0] max_q;

   // Sign-magnitude compare; +0 and -0 are equal so neither displaces the other.
   function automatic logic is_greater(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-2:0] mag_a, mag_b;
      mag_a = a[DATA_WIDTH-2:0];
      mag_b = b[DATA_WIDTH-2:0];
      if ((mag_a == '0) && (mag_b == '0)) return 1'b0;
      if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return b[DATA_WIDTH-1];
      if (!a[DATA_WIDTH-1]) return mag_a > mag_b;
      return mag_a < mag_b;
   endfunction

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)
         max_q <= '0;
      else if (wr_en && ((wr_idx == '0) || is_greater(data_i, max_q)))
         max_q <= data_i;
   end

   assign max_o = max_q;
`else
   assign max_o = '0;
`endif

   assign busy_o       = (state_q != IDLE);
   assign max_valid_o  = max_valid_q;
   assign data_valid_o = (state_q == REPLAY);
   assign data_o       = (state_q == REPLAY) ? mem[rd_ptr_q] : '0;
   assign index_o      = (state_q == REPLAY) ? rd_ptr_q : '0;
   assign last_o       = (state_q == REPLAY) && (rd_ptr_q == LAST_IDX);

endmodule
